handshake_monitor: RTL

HANDSHAKE_MONITOR -- requirements
Module: handshake_monitor

---
 rtl/handshake_monitor_pkg.sv | 21 ++
 rtl/handshake_channel_checker.sv | 96 +++++++++
 rtl/handshake_monitor.sv | 88 ++++++++
 3 files changed

// File: rtl/handshake_monitor_pkg.sv
// handshake_monitor_pkg: shared types and helpers for the ready/valid handshake monitor.
//   err_code_e : per-channel error code (NONE, DROP, DATA_CHG, TIMEOUT)
//   state_e    : per-channel checker FSM state (IDLE, WAIT)
//   width_for  : bits needed to hold 0..max_val, at least 1
package handshake_monitor_pkg;
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_DROP     = 2'd1,
        ERR_DATA_CHG = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction
endpackage

// File: rtl/handshake_channel_checker.sv
// handshake_channel_checker: protocol checker and transfer counter for one ready/valid channel.
//   CLK, ASYNCRESETN : clock, async active-low reset
//   clear            : sync clear of FSM, counters and error state
//   valid/ready/data : observed channel
//   xfer_count       : saturating count of completed transfers
//   err_sticky       : an error has been seen since reset/clear
//   err_code         : first error seen
//   err_det          : an error is detected this cycle (combinational, consumed by registers only)
module handshake_channel_checker
    import handshake_monitor_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              ASYNCRESETN,
    input  logic              clear,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              err_sticky,
    output logic [1:0]        err_code,
    output logic              err_det
);
    localparam int ST_W = width_for(TIMEOUT);

    state_e            r_state, w_state_nxt;
    err_code_e         r_code, w_err;
    logic [DATA_W-1:0] r_cap;
    logic [ST_W-1:0]   r_stall, w_stall_nxt, w_stall_inc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sticky;

    // The stall that moves IDLE->WAIT is stall cycle 1, so a TIMEOUT-cycle
    // stall is flagged in the cycle where the incremented count reaches TIMEOUT.
    always_comb begin
        w_err       = ERR_NONE;
        w_state_nxt = r_state;
        w_stall_nxt = r_stall;
        w_stall_inc = (r_stall == '1) ? r_stall : r_stall + 1'b1;
        if (r_state == ST_IDLE) begin
            if (valid && !ready) begin
                w_state_nxt = ST_WAIT;
                w_stall_nxt = ST_W'(1);
            end
        end else begin
            if (!valid)
                w_err = ERR_DROP;
            else if (data != r_cap)
                w_err = ERR_DATA_CHG;
            else if (TIMEOUT != 0 && !ready && w_stall_inc >= ST_W'(TIMEOUT))
                w_err = ERR_TIMEOUT;
            w_stall_nxt = w_stall_inc;
            if (w_err != ERR_NONE || ready) begin
                w_state_nxt = ST_IDLE;
                w_stall_nxt = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state  <= ST_IDLE;
            r_cap    <= '0;
            r_stall  <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_code   <= ERR_NONE;
        end else if (clear) begin
            r_state  <= ST_IDLE;
            r_cap    <= '0;
            r_stall  <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_code   <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_stall <= w_stall_nxt;
            if (r_state == ST_IDLE && valid && !ready)
                r_cap <= data;
            if (valid && ready && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
            if (w_err != ERR_NONE && !r_sticky) begin
                r_sticky <= 1'b1;
                r_code   <= w_err;
            end
        end
    end

    assign xfer_count = r_cnt;
    assign err_sticky = r_sticky;
    assign err_code   = r_code;
    assign err_det    = (w_err != ERR_NONE);
endmodule

// File: rtl/handshake_monitor.sv
// handshake_monitor: observe-only monitor for N_CH ready/valid channels.
//   CLK, ASYNCRESETN : clock, async active-low reset
//   clear            : sync clear of all counters and error state
//   valid, ready     : per-channel handshake, bit i = channel i
//   data             : channel i payload at [i*DATA_W +: DATA_W]
//   xfer_count       : channel i count at [i*CNT_W +: CNT_W]
//   err_sticky       : per-channel error-seen flag
//   err_code         : channel i first error code at [2*i +: 2]
//   err_pulse        : one-cycle strobe after any cycle with a detected error
//   first_err_valid  : first error channel has been latched
//   first_err_ch     : channel of the first latched error
module handshake_monitor
    import handshake_monitor_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                               CLK,
    input  logic                               ASYNCRESETN,
    input  logic                               clear,
    input  logic [N_CH-1:0]                    valid,
    input  logic [N_CH-1:0]                    ready,
    input  logic [N_CH*DATA_W-1:0]             data,
    output logic [N_CH*CNT_W-1:0]              xfer_count,
    output logic [N_CH-1:0]                    err_sticky,
    output logic [N_CH*2-1:0]                  err_code,
    output logic                               err_pulse,
    output logic                               first_err_valid,
    output logic [width_for(N_CH-1)-1:0]       first_err_ch
);
    localparam int CH_W = width_for(N_CH - 1);

    logic [N_CH-1:0] w_det;
    logic [CH_W-1:0] w_first_ch;
    logic [CH_W-1:0] r_first_ch;
    logic            r_first_valid;
    logic            r_pulse;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        handshake_channel_checker #(
            .DATA_W  (DATA_W),
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_chk (
            .CLK         (CLK),
            .ASYNCRESETN (ASYNCRESETN),
            .clear       (clear),
            .valid       (valid[i]),
            .ready       (ready[i]),
            .data        (data[i*DATA_W +: DATA_W]),
            .xfer_count  (xfer_count[i*CNT_W +: CNT_W]),
            .err_sticky  (err_sticky[i]),
            .err_code    (err_code[2*i +: 2]),
            .err_det     (w_det[i])
        );
    end

    // Scan downward so the lowest detecting channel wins.
    always_comb begin
        w_first_ch = '0;
        for (int k = N_CH - 1; k >= 0; k--)
            if (w_det[k]) w_first_ch = CH_W'(k);
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_pulse       <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_ch    <= '0;
        end else if (clear) begin
            r_pulse       <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_ch    <= '0;
        end else begin
            r_pulse <= |w_det;
            if (!r_first_valid && |w_det) begin
                r_first_valid <= 1'b1;
                r_first_ch    <= w_first_ch;
            end
        end
    end

    assign err_pulse       = r_pulse;
    assign first_err_valid = r_first_valid;
    assign first_err_ch    = r_first_ch;
endmodule
